// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and constants for the LC3 memory responder
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;

  localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - 2-way round-robin grant between fetch and data ports
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
(
  input  logic       i_req_i,
  input  logic       i_req_d,
  input  logic       i_en,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  // One-hot grant; on a tie the port that did not win last time goes first.
  // The owner of i_last resets it to PORT_I so the data port wins the first tie.
  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      if (i_req_i && i_req_d) begin
        if (i_last == PORT_D) begin
          o_grant[PORT_I] = 1'b1;
        end else begin
          o_grant[PORT_D] = 1'b1;
        end
      end else if (i_req_d) begin
        o_grant[PORT_D] = 1'b1;
      end else if (i_req_i) begin
        o_grant[PORT_I] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - fixed-latency shared memory for LC3 fetch/data ports (optional LC3_MEM_PERF_EN counters)
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  busy
`ifdef LC3_MEM_PERF_EN
  ,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count,
  output logic [31:0]           conflict_count
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_port;
  logic                  r_last;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_i_ack;
  logic                  r_d_ack;
  logic [DATA_WIDTH-1:0] r_i_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  logic [1:0]            w_grant;
  logic                  w_idle;
  logic                  w_access;
  logic                  w_gport;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_access = (r_state == ST_WAIT) && (r_cnt == '0);
  assign w_gport  = w_grant[PORT_D] ? PORT_D : PORT_I;

  lc3_mem_arbiter u_arb (
    .i_req_i (i_req),
    .i_req_d (d_req),
    .i_en    (w_idle),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: accept in IDLE, count down in WAIT, single ack cycle in RESP.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (|w_grant) w_next_state = ST_WAIT;
      ST_WAIT: if (r_cnt == '0) w_next_state = ST_RESP;
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request latch, latency counter, round-robin pointer, acks and read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_port    <= PORT_I;
      r_last    <= PORT_I;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      if (|w_grant) begin
        r_port  <= w_gport;
        r_last  <= w_gport;
        r_we    <= (w_gport == PORT_D) ? d_we : 1'b0;
        r_addr  <= (w_gport == PORT_D) ? d_addr : i_addr;
        r_wdata <= d_wdata;
        r_cnt   <= CNT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_access) begin
        if (r_port == PORT_D) begin
          r_d_ack   <= 1'b1;
          r_d_rdata <= r_we ? '0 : r_mem[r_addr];
        end else begin
          r_i_ack   <= 1'b1;
          r_i_rdata <= r_mem[r_addr];
        end
      end
    end
  end

  // Backing array is never reset; a write only lands on the access edge.
  always_ff @(posedge clk) begin
    if (rst && w_access && r_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign i_ack   = r_i_ack;
  assign d_ack   = r_d_ack;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign busy    = (r_state != ST_IDLE);

`ifdef LC3_MEM_PERF_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;
  logic [31:0] r_conflict_count;

  // Activity counters: completed reads/writes and IDLE cycles with both ports requesting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_count       <= '0;
      r_wr_count       <= '0;
      r_conflict_count <= '0;
    end else begin
      if (w_access && !r_we) r_rd_count <= r_rd_count + 32'd1;
      if (w_access && r_we) r_wr_count <= r_wr_count + 32'd1;
      if (w_idle && i_req && d_req) r_conflict_count <= r_conflict_count + 32'd1;
    end
  end

  assign rd_count       = r_rd_count;
  assign wr_count       = r_wr_count;
  assign conflict_count = r_conflict_count;
`endif

endmodule
